param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: number of count states (0..MODULUS-1), legal range 2..2**WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; counter advances only when high.
REQ-006 m  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered count value.
REQ-010 tc  output  1  terminal count, combinational: high when en=1 and (m=1 and q=MODULUS-1, or m=0 and q=0).
REQ-011 wrap  output  1  registered one-cycle pulse, high in the cycle after q crossed a boundary.

Function
REQ-012 Priority per edge SHALL be rst > load > en; with none active, q holds.
REQ-013 load=1 SHALL set q=d on the next edge, independent of en and m.
REQ-014 load with d >= MODULUS SHALL set q=MODULUS-1 (clamp); no wrap pulse.
REQ-015 en=1, m=1, q<MODULUS-1: q SHALL become q+1 on the next edge.
REQ-016 en=1, m=0, q>0: q SHALL become q-1 on the next edge.
REQ-017 Boundary, up: en=1, m=1, q=MODULUS-1: q SHALL wrap to 0 (default build).
REQ-018 Boundary, down: en=1, m=0, q=0: q SHALL wrap to MODULUS-1 (default build).
REQ-019 wrap SHALL be 1 for exactly the one cycle following a boundary step per REQ-017/018, otherwise 0.
REQ-020 A direction change on m SHALL take effect at the very next enabled edge, with no extra latency.
REQ-021 Arithmetic SHALL use WIDTH bits only; with MODULUS=2**WIDTH the wrap SHALL match natural modulo-2**WIDTH overflow.
REQ-022 Latency from en/load/m sampling to q update SHALL be one clock.
REQ-023 tc SHALL be 0 whenever en=0.

Reset
REQ-024 rst=1 at an edge SHALL set q=0 and wrap=0, overriding load and en.
REQ-025 Reset asserted mid-count SHALL take effect at the next edge; counting resumes from 0 on the first edge after rst deasserts.
REQ-026 Before the first reset edge q is undefined; no behaviour is required.

Configuration
REQ-027 Macro UPDOWN_COUNTER_SATURATE_EN SHALL select boundary behaviour at compile time.
REQ-028 Without the macro, boundaries SHALL wrap per REQ-017/018.
REQ-029 With the macro, q SHALL hold at MODULUS-1 counting up and at 0 counting down, wrap SHALL stay 0, and tc SHALL still assert per REQ-010.

Verification (WIDTH=3, MODULUS=6 unless stated)
REQ-030 rst=1 for 2 cycles with load=1, d=5 -> q=0, wrap=0 after each edge.
REQ-031 en=1, m=1 from q=0 for 7 cycles -> q=1,2,3,4,5,0,1; tc=1 while q=5; wrap=1 only in the cycle after the 5->0 step.
REQ-032 load=1, d=2, then en=1, m=0 for 4 cycles -> q=2,1,0,5,4; wrap pulses once after the 0->5 step.
REQ-033 load=1, d=7 -> q=5; en=1, m=1, load=1, d=3 on the same edge -> q=3 (load wins).
REQ-034 Count up to q=3, toggle m=0 with en=1 -> q=2 on the next edge; en=0 for 3 cycles -> q holds at 2, tc=0.
REQ-035 Build with UPDOWN_COUNTER_SATURATE_EN, WIDTH=3, MODULUS=8: en=1, m=1 from q=6 for 3 cycles -> q=7,7,7, wrap=0; then m=0 from q=0 -> q holds at 0.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Bundle of the counter's control inputs and status outputs.
// master drives the controls; slave is the counter itself.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             m;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output en, m, load, d, input q, tc, wrap);
  modport slave  (input en, m, load, d, output q, tc, wrap);
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, wrap pulse and terminal count.
// Define UPDOWN_COUNTER_SATURATE_EN to hold at the boundaries instead of wrapping.
module param_updown_counter #(
  parameter int unsigned     WIDTH   = 3,
  parameter longint unsigned MODULUS = longint'(1) << WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  param_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             wrap_r;
  logic             wrap_next;
  logic             at_top;
  logic             at_bottom;

  assign at_top    = (q_r == MAX_Q);
  assign at_bottom = (q_r == '0);

  // Next count: load beats enable; boundary handling selected at compile time.
  always_comb begin
    q_next    = q_r;
    wrap_next = 1'b0;
    if (bus.load) begin
      if (64'(bus.d) >= MODULUS) begin
        q_next = MAX_Q;
      end else begin
        q_next = bus.d;
      end
    end else if (bus.en) begin
      if (bus.m) begin
        if (at_top) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
          q_next    = MAX_Q;
`else
          q_next    = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_r + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
          q_next    = '0;
`else
          q_next    = MAX_Q;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      wrap_r <= wrap_next;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = bus.en & (bus.m ? at_top : at_bottom);
endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: the driver queues expected results,
// separate monitors pop and compare tc (before the edge) and q/wrap (after it).
module tb_param_updown_counter;
  localparam int unsigned WIDTH = 3;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam longint unsigned MOD = 8;
`else
  localparam longint unsigned MOD = 6;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             wrap;
  } post_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  post_t post_q[$];
  logic  tc_q[$];

  param_updown_counter_if #(.WIDTH(WIDTH)) bus_i ();

  param_updown_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs and queue what must be seen.
  task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] dv,
                      input logic e, input logic mm,
                      input logic [WIDTH-1:0] eq, input logic ew, input logic etc);
    post_t p;
    @(posedge clk);
    #2;
    rst        = r;
    bus_i.load = ld;
    bus_i.d    = dv;
    bus_i.en   = e;
    bus_i.m    = mm;
    p.q        = eq;
    p.wrap     = ew;
    post_q.push_back(p);
    tc_q.push_back(etc);
  endtask

  // tc monitor: inputs are stable by the falling edge.
  initial begin
    logic etc;
    forever begin
      @(negedge clk);
      if (tc_q.size() > 0) begin
        etc = tc_q.pop_front();
        total++;
        if (bus_i.tc !== etc) begin
          bad++;
          $display("FAIL tc @%0t: got %b want %b (q=%0d)", $time, bus_i.tc, etc, bus_i.q);
        end
      end
    end
  end

  // q/wrap monitor: sampled just after the rising edge.
  initial begin
    post_t p;
    forever begin
      @(posedge clk);
      #1;
      if (post_q.size() > 0) begin
        p = post_q.pop_front();
        total++;
        if (bus_i.q !== p.q) begin
          bad++;
          $display("FAIL q @%0t: got %0d want %0d", $time, bus_i.q, p.q);
        end
        total++;
        if (bus_i.wrap !== p.wrap) begin
          bad++;
          $display("FAIL wrap @%0t: got %b want %b", $time, bus_i.wrap, p.wrap);
        end
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    bus_i.en   = 1'b0;
    bus_i.m    = 1'b0;
    bus_i.load = 1'b0;
    bus_i.d    = '0;

    //   rst ld d  en m   q  wrap tc
    step(1, 1, 5, 0, 0,  0, 0, 0);
    step(1, 1, 5, 0, 0,  0, 0, 0);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    step(0, 1, 6, 0, 0,  6, 0, 0);
    step(0, 0, 0, 1, 1,  7, 0, 0);
    step(0, 0, 0, 1, 1,  7, 0, 1);
    step(0, 0, 0, 1, 1,  7, 0, 1);
    step(1, 0, 0, 0, 0,  0, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 1);
    step(0, 0, 0, 1, 0,  0, 0, 1);
    step(0, 0, 0, 1, 1,  1, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0);
`else
    // Up through the wrap.
    step(0, 0, 0, 1, 1,  1, 0, 0);
    step(0, 0, 0, 1, 1,  2, 0, 0);
    step(0, 0, 0, 1, 1,  3, 0, 0);
    step(0, 0, 0, 1, 1,  4, 0, 0);
    step(0, 0, 0, 1, 1,  5, 0, 0);
    step(0, 0, 0, 1, 1,  0, 1, 1);
    step(0, 0, 0, 1, 1,  1, 0, 0);
    // Load then down through the wrap.
    step(0, 1, 2, 0, 0,  2, 0, 0);
    step(0, 0, 0, 1, 0,  1, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0);
    step(0, 0, 0, 1, 0,  5, 1, 1);
    step(0, 0, 0, 1, 0,  4, 0, 0);
    // Clamped load, then load beating count at the top.
    step(0, 1, 7, 0, 0,  5, 0, 0);
    step(0, 1, 3, 1, 1,  3, 0, 1);
    // Direction change and hold.
    step(1, 0, 0, 1, 1,  0, 0, 0);
    step(0, 0, 0, 1, 1,  1, 0, 0);
    step(0, 0, 0, 1, 1,  2, 0, 0);
    step(0, 0, 0, 1, 1,  3, 0, 0);
    step(0, 0, 0, 1, 0,  2, 0, 0);
    step(0, 0, 0, 0, 0,  2, 0, 0);
    step(0, 0, 0, 0, 1,  2, 0, 0);
    step(0, 0, 0, 0, 0,  2, 0, 0);
    // Reset mid-count, en=0 at zero gives no tc, then resume.
    step(1, 1, 4, 1, 1,  0, 0, 0);
    step(0, 0, 0, 0, 0,  0, 0, 0);
    step(0, 0, 0, 1, 1,  1, 0, 0);
    step(0, 0, 0, 1, 0,  0, 0, 0);
    step(0, 0, 0, 1, 0,  5, 1, 1);
    step(0, 0, 0, 1, 0,  4, 0, 0);
`endif
    @(posedge clk);
    #2;
    bus_i.en   = 1'b0;
    bus_i.load = 1'b0;
    rst        = 1'b0;
    for (int i = 0; i < 10 && (post_q.size() > 0 || tc_q.size() > 0); i++) begin
      @(posedge clk);
    end
    #3;
    total++;
    if (post_q.size() != 0 || tc_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d entries left, want 0", post_q.size(), tc_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
